mult_operand_issuer: RTL

Upstream issue stage for the 4x4 shift-add multiplier (shift_add_multi2).
- Accepts operand pairs on a valid/ready interface and buffers them in a small FIFO.
- Drives the multiplier's a/b inputs phase-aligned to its internal 0..4 step counter, then samples the 8-bit product.
- Returns the result on a valid/ready output interface.
- Hides the multiplier's free-running sequencing and its non-clearing accumulator from the rest of the design.

---
 rtl/mult_issue_pkg.sv | 22 ++
 rtl/mult_op_fifo.sv | 54 +++++
 rtl/mult_operand_issuer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mult_issue_pkg.sv
// Shared types and constants for the shift-add multiplier issue stage.
package mult_issue_pkg;

  localparam int unsigned OP_W_DEF      = 4;
  localparam int unsigned RES_W_DEF     = 8;
  localparam int unsigned PHASE_MOD_DEF = 5;
  localparam int unsigned DEPTH_DEF     = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    HOLD    = 3'd2,
    CAPTURE = 3'd3,
    OUT     = 3'd4
  } state_e;

  // Bits needed to index 'depth' entries (at least 1).
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/mult_op_fifo.sv
// Synchronous operand FIFO with show-ahead read data; DEPTH must be a power of two.
module mult_op_fifo
  import mult_issue_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned DW    = 2 * OP_W_DEF
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned AW = ptr_w(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic          do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  // Pointer advance on accepted push/pop.
  always_comb begin
    wptr_d = do_push ? (wptr_q + PTR_ONE) : wptr_q;
    rptr_d = do_pop  ? (rptr_q + PTR_ONE) : rptr_q;
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/mult_operand_issuer.sv
// Issue stage for the free-running 4x4 shift-add multiplier: buffers operand
// pairs, aligns them to the multiplier step counter, clears its accumulator,
// and returns the product on a valid/ready interface.
// Optional: MULT_ZERO_BYPASS_EN lets pairs with a zero operand skip the multiplier.
module mult_operand_issuer
  import mult_issue_pkg::*;
#(
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned PHASE_MOD = PHASE_MOD_DEF,
  parameter int unsigned OP_W      = OP_W_DEF,
  parameter int unsigned RES_W     = RES_W_DEF
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [OP_W-1:0]  op_a,
  input  logic [OP_W-1:0]  op_b,
  output logic [OP_W-1:0]  mul_a,
  output logic [OP_W-1:0]  mul_b,
  input  logic [RES_W-1:0] mul_product,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [RES_W-1:0] res_data,
  output logic             busy
);

  localparam int unsigned     PH_W    = ptr_w(PHASE_MOD);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PHASE_MOD - 1);
  localparam logic [PH_W-1:0] PH_POP  = PH_W'(PHASE_MOD - 2);

  logic [PH_W-1:0]  phase_q, phase_d;
  state_e           state_q, state_d;
  logic [OP_W-1:0]  lat_a_q, lat_a_d, lat_b_q, lat_b_d;
  logic             res_valid_q, res_valid_d;
  logic [RES_W-1:0] res_data_q, res_data_d;

  logic             fifo_full, fifo_empty, pop;
  logic [OP_W-1:0]  head_a, head_b;
  logic             head_zero;

  mult_op_fifo #(
    .DEPTH(DEPTH),
    .DW   (2 * OP_W)
  ) u_fifo (
    .clk    (clk),
    .n_rst  (n_rst),
    .push_i (op_valid),
    .wdata_i({op_a, op_b}),
    .pop_i  (pop),
    .rdata_o({head_a, head_b}),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

`ifdef MULT_ZERO_BYPASS_EN
  assign head_zero = (head_a == '0) || (head_b == '0);
`else
  assign head_zero = 1'b0;
`endif

  // Phase mirror of the multiplier step counter (shares clk/n_rst with it).
  always_comb begin
    phase_d = (phase_q == PH_LAST) ? '0 : (phase_q + PH_W'(1));
  end

  // Issue FSM: align pop so CLEAR lands on the last step and HOLD spans a full period.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    lat_a_d     = lat_a_q;
    lat_b_d     = lat_b_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          if (head_zero) begin
            pop         = 1'b1;
            res_valid_d = 1'b1;
            res_data_d  = '0;
            state_d     = OUT;
          end else if (phase_q == PH_POP) begin
            pop     = 1'b1;
            lat_a_d = head_a;
            lat_b_d = head_b;
            state_d = CLEAR;
          end
        end
      end
      CLEAR:   state_d = HOLD;
      HOLD:    if (phase_q == PH_LAST) state_d = CAPTURE;
      CAPTURE: begin
        res_data_d  = mul_product;
        res_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand latch and result registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      phase_q     <= '0;
      state_q     <= IDLE;
      lat_a_q     <= '0;
      lat_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      phase_q     <= phase_d;
      state_q     <= state_d;
      lat_a_q     <= lat_a_d;
      lat_b_q     <= lat_b_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign mul_a     = (state_q == HOLD) ? lat_a_q : '0;
  assign mul_b     = (state_q == HOLD) ? lat_b_q : '0;
  assign op_ready  = !fifo_full;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule
